// File: rtl/instruction_prefetch.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a circular {pc, ir} FIFO and flushes it on a redirect from later stages.
module instruction_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_ir,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]       state, state_nxt;
  logic [31:0]      fetch_pc, fetch_pc_nxt;
  logic [31:0]      addr_nxt;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      ir_q [DEPTH];

  logic             push, pop, full;
  logic [31:0]      redirect_pc_aligned;
  logic [31:0]      addr_inc;
  logic [CNT_W:0]   cnt_after_push;

  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
  assign addr_inc            = imem_addr + 32'd4;

  assign if_valid = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign imem_req = (state == REQ) || (state == DISCARD);

  // Redirect suppresses both queue operations; the flush wins.
  assign push = (state == REQ) && imem_ack && !redirect;
  assign pop  = if_valid && if_ready && !redirect;

  // Occupancy the queue will have once this cycle's push and pop land.
  assign cnt_after_push = {1'b0, count} + (CNT_W+1)'(1) - {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    addr_nxt     = imem_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc_aligned;
        end else if (!full) begin
          state_nxt = REQ;
          addr_nxt  = fetch_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc_aligned;
          state_nxt    = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          fetch_pc_nxt = addr_inc;
          if (cnt_after_push < (CNT_W+1)'(DEPTH)) begin
            addr_nxt = addr_inc;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        // Stale request stays on the bus until memory answers; its data is dropped.
        if (redirect) begin
          fetch_pc_nxt = redirect_pc_aligned;
        end
        if (imem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC_ALIGNED;
      imem_addr <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_addr <= addr_nxt;
      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail] <= imem_addr;
      ir_q[tail] <= imem_rdata;
    end
  end

  assign if_pc   = if_valid ? pc_q[head] : '0;
  assign if_ir   = if_valid ? ir_q[head] : '0;
  assign q_count = count;

endmodule
